// File: rtl/btn_repeat.sv
// Debounced multi-channel push-button controller with press strobe and optional auto-repeat.
// Build option: define BTN_REPEAT_AUTOREPEAT_EN to enable hold-to-repeat pulses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | released, waiting for a press
// PRESS_DB | press seen, waiting DB_TICKS stable ticks to accept it
// HELD     | press accepted, counting HOLD_TICKS toward auto-repeat
// REPEAT   | auto-repeating, one pulse every RPT_TICKS ticks
// REL_DB   | release seen, waiting DB_TICKS stable ticks to accept it
module btn_repeat #(
    parameter int CHANNELS   = 2,
    parameter int TICK_DIV   = 1000,
    parameter int DB_TICKS   = 16,
    parameter int HOLD_TICKS = 500,
    parameter int RPT_TICKS  = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_n_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_pulse,
    output logic                any_held
);

    localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_A    = (DB_TICKS > HOLD_TICKS) ? DB_TICKS : HOLD_TICKS;
    localparam int CNT_MAX  = (MAX_A > RPT_TICKS) ? MAX_A : RPT_TICKS;
    localparam int CW       = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        HELD     = 3'd2,
        REPEAT   = 3'd3,
        REL_DB   = 3'd4
    } state_t;

    logic [PW-1:0]       pre_cnt;
    logic                tick;
    logic [CHANNELS-1:0] sync_1;
    logic [CHANNELS-1:0] sync_2;
    logic [CHANNELS-1:0] pressed;

    assign tick = (pre_cnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Synchronizers reset to the released level so a held button is re-debounced after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '1;
            sync_2 <= '1;
        end else begin
            sync_1 <= btn_n_in;
            sync_2 <= sync_1;
        end
    end

    assign pressed = ~sync_2;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t        state;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_inc;
        logic          level_r;
        logic          pulse_r;
        logic          db_hit;
        logic          rpt_hit;

        // Counter stops at all-ones so a long HELD without auto-repeat never wraps.
        assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
        assign db_hit  = (cnt == CW'(DB_TICKS - 1));
        assign rpt_hit = (cnt == CW'(RPT_TICKS - 1));
`ifdef BTN_REPEAT_AUTOREPEAT_EN
        logic hold_hit;
        assign hold_hit = (cnt == CW'(HOLD_TICKS - 1));
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= IDLE;
                cnt     <= '0;
                level_r <= 1'b0;
                pulse_r <= 1'b0;
            end else begin
                pulse_r <= 1'b0;
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (pressed[i]) begin
                            state <= PRESS_DB;
                        end
                    end
                    PRESS_DB: begin
                        if (!pressed[i]) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (tick) begin
                            if (db_hit) begin
                                state   <= HELD;
                                cnt     <= '0;
                                level_r <= 1'b1;
                                pulse_r <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                    end
                    HELD: begin
                        if (!pressed[i]) begin
                            state <= REL_DB;
                            cnt   <= '0;
                        end else if (tick) begin
`ifdef BTN_REPEAT_AUTOREPEAT_EN
                            if (hold_hit) begin
                                state   <= REPEAT;
                                cnt     <= '0;
                                pulse_r <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
`else
                            cnt <= cnt_inc;
`endif
                        end
                    end
                    REPEAT: begin
                        if (!pressed[i]) begin
                            state <= REL_DB;
                            cnt   <= '0;
                        end else if (tick) begin
                            if (rpt_hit) begin
                                cnt     <= '0;
                                pulse_r <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                    end
                    REL_DB: begin
                        if (pressed[i]) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (tick) begin
                            if (db_hit) begin
                                state   <= IDLE;
                                cnt     <= '0;
                                level_r <= 1'b0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cnt     <= '0;
                        level_r <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_level[i] = level_r;
        assign btn_pulse[i] = pulse_r;
    end

    assign any_held = |btn_level;

endmodule
